coef_readback_tx: RTL
=====================

Name: coef_readback_tx

Overview:
Reads back the 16 FIR coefficients currently held by the coefficient-load block and streams them out as a byte frame toward the UART transmitter. It is the reverse path of coefficient loading: host writes coefficients in, this block dumps them out for verification. It sits between the coefficient register bank and the UART TX byte interface, and is clocked on the 100 MHz system clock.

Parameters:
N_COEF, 16, number of coefficients in the bank
COEF_W, 12, coefficient width in bits, two's complement; legal range 9..16
HEADER, 8'hA5, frame start byte

Ports:
clk_100MHz_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
dump_i  input  1  request to start a frame; level sampled each cycle, acted on only in IDLE
coefs_i  input  N_COEF*COEF_W  flattened bank; coef k at coefs_i[COEF_W*k +: COEF_W]
tx_data_o  output  8  byte to UART TX
tx_valid_o  output  1  tx_data_o valid
tx_ready_i  input  1  UART TX accepts byte; transfer when tx_valid_o & tx_ready_i on a rising edge
busy_o  output  1  frame in progress
done_o  output  1  one-cycle pulse after the last byte is transferred

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE; tx_valid_o=0, tx_data_o=8'h00, busy_o=0, done_o=0; byte index and checksum cleared. This takes priority over everything, including mid-frame: the frame aborts, tx_valid_o drops at that edge, no done_o.
- FSM states: IDLE, SEND_HDR, SEND_DATA, SEND_CHK, DONE.
- IDLE: when dump_i=1 at edge n, the block snapshots coefs_i into an internal shadow register, clears checksum and byte index, and enters SEND_HDR. After edge n: tx_valid_o=1, tx_data_o=HEADER, busy_o=1. dump_i has single-cycle latency to the first valid byte.
- Frame: HEADER, then 2*N_COEF data bytes, then 1 checksum byte. The default frame is 34 bytes.
- Data byte order: coef 0 first. For each coef c, the high byte goes first, then the low byte. c is sign-extended to 16 bits. high = ext[15:8], low = ext[7:0]. For COEF_W=12, high = {4{c[11]}, c[11:8]}.
- Checksum = XOR of all 2*N_COEF data bytes. HEADER is excluded.
- Handshake: once tx_valid_o is asserted, tx_data_o and tx_valid_o stay stable until the transfer edge. The next byte is presented on the cycle after the transfer. With tx_ready_i held at 1, there is one byte per cycle and no bubbles. The block never deasserts valid without a transfer, except on reset.
- The checksum accumulates on each data-byte transfer edge, not on presentation.
- Byte index counts 0..2*N_COEF-1 in SEND_DATA. On the transfer of index 2*N_COEF-1 the FSM moves to SEND_CHK.
- SEND_CHK: on transfer, go to DONE. tx_valid_o=0 and busy_o=0 after that edge. done_o=1 for exactly that one cycle.
- DONE returns to IDLE the next cycle. A dump_i held high across DONE starts a new frame from IDLE, so the minimum gap between frames is 1 idle cycle.
- dump_i while busy_o=1 is ignored: no restart and no queueing.
- coefs_i changes after the snapshot do not affect the frame in flight.
- busy_o=1 from the cycle after acceptance through the checksum transfer edge inclusive.

Test Plan:
- Symmetric set, tx_ready_i=1: load coef0..15 = -99,65,136,33,-156,-86,376,854,854,376,-86,-156,33,136,65,-99 and pulse dump_i. Expect 34 consecutive valid cycles carrying A5 FF 9D 00 41 00 88 00 21 FF 64 FF AA 01 78 03 56 03 56 01 78 FF AA FF 64 00 21 00 88 00 41 FF 9D 00. The checksum is 00. done_o pulses one cycle after the 00 transfer, and the first valid byte appears one cycle after dump_i.
- Asymmetric checksum: coef0=1, all others 0. Expect A5 00 01, then 30×00, then checksum 01.
- Backpressure: same set as the first scenario, with tx_ready_i toggling 1 cycle high / 3 cycles low (UART-like). Expect the identical byte sequence. tx_data_o must stay stable whenever valid=1 and ready=0. done_o is asserted only once.
- Snapshot and ignore: during byte 5, change coefs_i to all 0 and pulse dump_i. Expect the frame to still match the first scenario, with no second frame.
- Reset mid-frame: assert rst_i for 1 cycle at byte 10. Expect tx_valid_o=0, busy_o=0 and done_o=0 after that edge. A subsequent dump_i produces a complete, correct frame whose checksum is unaffected by the aborted one.
- Back-to-back: hold dump_i=1 continuously. Expect frames separated by exactly the DONE and IDLE cycles, each starting with A5.

Source files
------------

// File: rtl/coef_readback_tx.sv
// Coefficient readback framer: snapshots the FIR coefficient bank and streams
// HEADER, sign-extended big-endian coefficient bytes and an XOR checksum to a UART TX.
module coef_readback_tx #(
    parameter int unsigned N_COEF = 16,
    parameter int unsigned COEF_W = 12,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic                     clk_100MHz_i,
    input  logic                     rst_i,
    input  logic                     dump_i,
    input  logic [N_COEF*COEF_W-1:0] coefs_i,
    output logic [7:0]               tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned N_BYTES = 2 * N_COEF;
    localparam int unsigned IDX_W   = $clog2(N_BYTES);
    localparam int unsigned CIDX_W  = IDX_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_HDR,
        S_SEND_DATA,
        S_SEND_CHK,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [COEF_W-1:0]   r_shadow [N_COEF];
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_chk;

    logic                w_xfer;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [CIDX_W-1:0]   w_coef_idx;
    logic signed [COEF_W-1:0] w_coef;
    logic [15:0]         w_ext;
    logic [7:0]          w_byte;

    // Next data byte to present: index 0 after the header, else the one after r_idx
    assign w_xfer     = tx_valid_o & tx_ready_i;
    assign w_sel_idx  = (r_state == S_SEND_DATA) ? (r_idx + IDX_W'(1)) : '0;
    assign w_coef_idx = w_sel_idx[IDX_W-1:1];
    assign w_coef     = r_shadow[w_coef_idx];
    assign w_ext      = 16'(w_coef);
    assign w_byte     = w_sel_idx[0] ? w_ext[7:0] : w_ext[15:8];

    always_ff @(posedge clk_100MHz_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_chk      <= 8'h00;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dump_i) begin
                        for (int k = 0; k < int'(N_COEF); k++) begin
                            r_shadow[k] <= coefs_i[COEF_W*k +: COEF_W];
                        end
                        r_chk      <= 8'h00;
                        r_idx      <= '0;
                        tx_data_o  <= HEADER;
                        tx_valid_o <= 1'b1;
                        busy_o     <= 1'b1;
                        r_state    <= S_SEND_HDR;
                    end
                end
                S_SEND_HDR: begin
                    if (w_xfer) begin
                        tx_data_o <= w_byte;
                        r_idx     <= '0;
                        r_state   <= S_SEND_DATA;
                    end
                end
                S_SEND_DATA: begin
                    // Checksum folds in each data byte as it is accepted
                    if (w_xfer) begin
                        r_chk <= r_chk ^ tx_data_o;
                        if (r_idx == IDX_W'(N_BYTES - 1)) begin
                            tx_data_o <= r_chk ^ tx_data_o;
                            r_state   <= S_SEND_CHK;
                        end else begin
                            r_idx     <= r_idx + IDX_W'(1);
                            tx_data_o <= w_byte;
                        end
                    end
                end
                S_SEND_CHK: begin
                    if (w_xfer) begin
                        tx_data_o  <= 8'h00;
                        tx_valid_o <= 1'b0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
